// File: rtl/llc_requester.sv
// Four-port LLC requester: each port runs an independent
// IDLE -> ISSUE -> WAIT -> DELIVER engine with one outstanding request.
module llc_requester #(
  parameter int         DATA_W  = 64,
  parameter logic [7:0] TIMEOUT = 8'd64
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [3:0]            req_valid,
  output logic [3:0]            req_ready,
  input  logic [4*DATA_W-1:0]   req_data,
  output logic [3:0]            llc_so,
  input  logic [3:0]            llc_ro,
  output logic [4*DATA_W-1:0]   llc_do,
  input  logic [3:0]            llc_si_r,
  output logic [3:0]            llc_ri_r,
  input  logic [4*DATA_W-1:0]   llc_di_r,
  output logic [3:0]            rsp_valid,
  input  logic [3:0]            rsp_ready,
  output logic [4*DATA_W-1:0]   rsp_data,
  output logic [31:0]           lat_last,
  output logic [3:0]            timeout_err
);

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_ISSUE   = 2'd1,
    ST_WAIT    = 2'd2,
    ST_DELIVER = 2'd3
  } state_t;

  for (genvar i = 0; i < 4; i++) begin : g_port
    state_t            r_state;
    state_t            w_next;
    logic [DATA_W-1:0] r_req;
    logic [DATA_W-1:0] r_rsp;
    logic [7:0]        r_timer;
    logic [7:0]        r_lat;
    logic              r_err;
    logic              w_req_ready;
    logic              w_so;
    logic              w_ri;
    logic              w_rsp_valid;

    // NOTE: state is updated with <= so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
      if (reset) r_state <= ST_IDLE;
      else       r_state <= w_next;
    end

    // NOTE: w_next defaults to the current state, so no path leaves it unassigned (no latch).
    always_comb begin
      w_next = r_state;
      case (r_state)
        ST_IDLE:    if (req_valid[i]) w_next = ST_ISSUE;
        ST_ISSUE:   if (llc_ro[i])    w_next = ST_WAIT;
        ST_WAIT:    if (llc_si_r[i])  w_next = ST_DELIVER;
        ST_DELIVER: if (rsp_ready[i]) w_next = ST_IDLE;
        default:                      w_next = ST_IDLE;
      endcase
    end

    // Handshake outputs depend on the state register only.
    always_comb begin
      w_req_ready = (r_state == ST_IDLE);
      w_so        = (r_state == ST_ISSUE);
      w_ri        = (r_state == ST_WAIT);
      w_rsp_valid = (r_state == ST_DELIVER);
    end

    always_ff @(posedge clk) begin
      if (reset) begin
        r_req   <= '0;
        r_rsp   <= '0;
        r_timer <= '0;
        r_lat   <= '0;
        r_err   <= 1'b0;
      end else begin
        case (r_state)
          ST_IDLE: if (req_valid[i]) r_req <= req_data[DATA_W*i +: DATA_W];
          ST_ISSUE: if (llc_ro[i]) r_timer <= '0;
          ST_WAIT: begin
            if (llc_si_r[i]) begin
              r_rsp <= llc_di_r[DATA_W*i +: DATA_W];
              r_lat <= (r_timer == 8'hFF) ? 8'hFF : r_timer + 8'd1;
            end else begin
              if (r_timer != 8'hFF) r_timer <= r_timer + 8'd1;
              // Sticky: the port keeps waiting, only reset clears the flag.
              if (r_timer == TIMEOUT) r_err <= 1'b1;
            end
          end
          default: ;
        endcase
      end
    end

    assign req_ready[i]                = w_req_ready;
    assign llc_so[i]                   = w_so;
    assign llc_ri_r[i]                 = w_ri;
    assign rsp_valid[i]                = w_rsp_valid;
    assign timeout_err[i]              = r_err;
    assign llc_do[DATA_W*i +: DATA_W]  = r_req;
    assign rsp_data[DATA_W*i +: DATA_W] = r_rsp;
    assign lat_last[8*i +: 8]          = r_lat;
  end

endmodule
